// File: rtl/actuator_sched.sv
// actuator_sched: single-owner scheduler driving a motor and a heater from button, UART and light requests.
// Define LIGHT_AUTO_EN to enable the light-level auto-run source (otherwise spi_done/led_data are ignored).
module actuator_sched #(
  parameter int unsigned TICK_DIV  = 100,
  parameter int unsigned MOTOR_SEC = 5,
  parameter int unsigned HEAT_SEC  = 3,
  parameter logic [7:0]  LIGHT_TH  = 8'h40
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       bt_start,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic [7:0] led_data,
  input  logic       spi_done,
  output logic       motor_signal,
  output logic       heat_signal,
  output logic       busy,
  output logic [1:0] grant,
  output logic       done_pulse
);

  localparam int unsigned PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SEC_MAX = (MOTOR_SEC > HEAT_SEC) ? MOTOR_SEC : HEAT_SEC;
  localparam int unsigned SEC_W   = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;

  localparam logic [7:0] BYTE_ABORT = 8'h30;
  localparam logic [7:0] BYTE_MOTOR = 8'h31;
  localparam logic [7:0] BYTE_HEAT  = 8'h32;

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_BTN  = 2'b01;
  localparam logic [1:0] G_UART = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_MOTOR, S_HEAT, S_GAP} state_t;

  state_t           state;
  state_t           state_nx;
  logic [PRE_W-1:0] pre;
  logic [SEC_W-1:0] sec;
  logic             btn_p;
  logic             um_p;
  logic             uh_p;
  logic             req_um_c;
  logic             req_uh_c;
  logic             abort_c;
  logic             pre_last_c;
  logic             motor_end_c;
  logic             heat_end_c;
  logic             take_btn_c;
  logic             take_um_c;
  logic             take_uh_c;
  logic             motor_nx;
  logic             heat_nx;
  logic             busy_nx;
  logic             done_nx;
  logic [1:0]       grant_nx;

  assign req_um_c    = rx_done && (rx_data == BYTE_MOTOR);
  assign req_uh_c    = rx_done && (rx_data == BYTE_HEAT);
  assign abort_c     = rx_done && (rx_data == BYTE_ABORT);
  assign pre_last_c  = (pre == PRE_W'(TICK_DIV - 1));
  assign motor_end_c = pre_last_c && (sec == SEC_W'(MOTOR_SEC - 1));
  assign heat_end_c  = pre_last_c && (sec == SEC_W'(HEAT_SEC - 1));

`ifdef LIGHT_AUTO_EN
  localparam logic [1:0] G_LIGHT = 2'b11;

  logic lt_p;
  logic req_lt_c;
  logic take_lt_c;

  assign req_lt_c = spi_done && (led_data < LIGHT_TH);

  // Light pending bit; a new request in the grant cycle keeps it set
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) lt_p <= 1'b0;
    else        lt_p <= (lt_p & ~(abort_c | take_lt_c)) | req_lt_c;
  end
`else
  logic unused_light;
  assign unused_light = ^{spi_done, led_data, LIGHT_TH};
`endif

  // One-deep pending bits; set dominates the grant clear
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      btn_p <= 1'b0;
      um_p  <= 1'b0;
      uh_p  <= 1'b0;
    end else begin
      btn_p <= (btn_p & ~(abort_c | take_btn_c)) | bt_start;
      um_p  <= (um_p  & ~(abort_c | take_um_c))  | req_um_c;
      uh_p  <= (uh_p  & ~(abort_c | take_uh_c))  | req_uh_c;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next state and arbitration: heat-UART > motor-UART > button > light
  always_comb begin
    state_nx   = state;
    take_btn_c = 1'b0;
    take_um_c  = 1'b0;
    take_uh_c  = 1'b0;
`ifdef LIGHT_AUTO_EN
    take_lt_c  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (!abort_c) begin
          if (uh_p) begin
            state_nx  = S_HEAT;
            take_uh_c = 1'b1;
          end else if (um_p) begin
            state_nx  = S_MOTOR;
            take_um_c = 1'b1;
          end else if (btn_p) begin
            state_nx   = S_MOTOR;
            take_btn_c = 1'b1;
          end
`ifdef LIGHT_AUTO_EN
          else if (lt_p) begin
            state_nx  = S_MOTOR;
            take_lt_c = 1'b1;
          end
`endif
        end
      end
      S_MOTOR: if (abort_c || motor_end_c) state_nx = S_GAP;
      S_HEAT:  if (abort_c || heat_end_c)  state_nx = S_GAP;
      S_GAP:   if (pre_last_c)             state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Prescaler and tick counter restart on every state entry
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pre <= '0;
      sec <= '0;
    end else if ((state_nx != state) || (state == S_IDLE)) begin
      pre <= '0;
      sec <= '0;
    end else if (pre_last_c) begin
      pre <= '0;
      sec <= sec + SEC_W'(1);
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // Output decode from the upcoming state so outputs track the transition edge
  always_comb begin
    motor_nx = (state_nx == S_MOTOR);
    heat_nx  = (state_nx == S_HEAT);
    busy_nx  = (state_nx != S_IDLE);
    done_nx  = !abort_c && (((state == S_MOTOR) && motor_end_c) ||
                            ((state == S_HEAT) && heat_end_c));
    grant_nx = G_NONE;
    if ((state_nx == S_MOTOR) || (state_nx == S_HEAT)) begin
      if (state != S_IDLE)               grant_nx = grant;
      else if (take_uh_c || take_um_c)   grant_nx = G_UART;
      else if (take_btn_c)               grant_nx = G_BTN;
`ifdef LIGHT_AUTO_EN
      else if (take_lt_c)                grant_nx = G_LIGHT;
`endif
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      motor_signal <= 1'b0;
      heat_signal  <= 1'b0;
      busy         <= 1'b0;
      grant        <= G_NONE;
      done_pulse   <= 1'b0;
    end else begin
      motor_signal <= motor_nx;
      heat_signal  <= heat_nx;
      busy         <= busy_nx;
      grant        <= grant_nx;
      done_pulse   <= done_nx;
    end
  end

endmodule

// File: tb/tb_actuator_sched.sv
// Bench for actuator_sched: directed stimulus, expected runs queued at stimulus time and checked by an output monitor.
module tb_actuator_sched;

  logic       clk      = 1'b0;
  logic       n_rst    = 1'b0;
  logic       bt_start = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_done  = 1'b0;
  logic [7:0] led_data = 8'h00;
  logic       spi_done = 1'b0;
  logic       motor_signal;
  logic       heat_signal;
  logic       busy;
  logic [1:0] grant;
  logic       done_pulse;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit         motor;
    logic [1:0] grant;
    int         len;
    int         done;
    int         gap;
  } exp_t;

  exp_t sb[$];

  actuator_sched #(
    .TICK_DIV (10),
    .MOTOR_SEC(2),
    .HEAT_SEC (1),
    .LIGHT_TH (8'h40)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .bt_start    (bt_start),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .led_data    (led_data),
    .spi_done    (spi_done),
    .motor_signal(motor_signal),
    .heat_signal (heat_signal),
    .busy        (busy),
    .grant       (grant),
    .done_pulse  (done_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input bit m, input logic [1:0] g, input int l, input int d, input int gp);
    exp_t e;
    e.motor = m;
    e.grant = g;
    e.len   = l;
    e.done  = d;
    e.gap   = gp;
    sb.push_back(e);
  endtask

  // Monitor: measures each run (kind, grant, length, done pulses) and the dead time after it
  bit         in_run = 1'b0;
  bit         in_gap = 1'b0;
  bit         r_motor;
  logic [1:0] r_grant;
  int         run_len;
  int         gap_len;
  int         done_cnt;
  logic       cur_run;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (!n_rst) begin
      in_run = 1'b0;
      in_gap = 1'b0;
    end else begin
      cur_run = motor_signal | heat_signal;
      chk("overlap", motor_signal & heat_signal, 1'b0);
      if (in_run && !(cur_run && (motor_signal == r_motor))) begin
        in_run  = 1'b0;
        in_gap  = 1'b1;
        gap_len = 0;
      end
      if (in_gap && (cur_run || !busy)) begin
        in_gap = 1'b0;
        chk("run_expected", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("run_kind",  r_motor,  mon_e.motor);
          chk("run_grant", r_grant,  mon_e.grant);
          chk("run_len",   run_len,  mon_e.len);
          chk("run_done",  done_cnt, mon_e.done);
          chk("gap_len",   gap_len,  mon_e.gap);
        end
      end
      if (!in_run && !in_gap && cur_run) begin
        in_run   = 1'b1;
        r_motor  = motor_signal;
        r_grant  = grant;
        run_len  = 0;
        done_cnt = 0;
      end
      if (in_run) run_len++;
      if (in_gap) gap_len++;
      if ((in_run || in_gap) && done_pulse) done_cnt++;
    end
  end

  task automatic send_rx(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic pulse_bt();
    bt_start = 1'b1;
    @(negedge clk);
    bt_start = 1'b0;
  endtask

  task automatic wait_run(input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (motor_signal || heat_signal) begin
        got = 1'b1;
        break;
      end
    end
    chk("run_start_timeout", got, 1'b1);
  endtask

  task automatic wait_gap(input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!motor_signal && !heat_signal) begin
        got = 1'b1;
        break;
      end
    end
    chk("run_end_timeout", got, 1'b1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && (sb.size() == 0)) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, got, 1'b1);
  endtask

  task automatic quiet(input int n, input string tag);
    logic act = 1'b0;
    repeat (n) begin
      @(negedge clk);
      act = act | busy | motor_signal | heat_signal | done_pulse | (grant != 2'b00);
    end
    chk(tag, act, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_motor", motor_signal, 1'b0);
    chk("rst_heat",  heat_signal,  1'b0);
    chk("rst_busy",  busy,         1'b0);
    chk("rst_grant", grant,        2'b00);
    chk("rst_done",  done_pulse,   1'b0);

    // UART motor request on the first edge after release
    #2 n_rst = 1'b1;
    push_exp(1'b1, 2'b10, 20, 1, 10);
    send_rx(8'h31);
    chk("lat_pending", motor_signal, 1'b0);
    @(negedge clk);
    chk("lat_motor", motor_signal, 1'b1);
    chk("lat_grant", grant, 2'b10);
    chk("lat_busy",  busy, 1'b1);
    wait_idle(200, "idle_uart_motor");

    // Button and UART heat in the same cycle: heat wins, button served after dead time
    push_exp(1'b0, 2'b10, 10, 1, 10);
    push_exp(1'b1, 2'b01, 20, 1, 10);
    bt_start = 1'b1;
    send_rx(8'h32);
    bt_start = 1'b0;
    wait_idle(300, "idle_heat_then_motor");

    // Unknown byte and bright light sample do nothing
    rx_data  = 8'h35;
    rx_done  = 1'b1;
    led_data = 8'h50;
    spi_done = 1'b1;
    @(negedge clk);
    rx_done  = 1'b0;
    spi_done = 1'b0;
    quiet(30, "quiet_ignored");

    // Dark light sample
`ifdef LIGHT_AUTO_EN
    push_exp(1'b1, 2'b11, 20, 1, 10);
`endif
    led_data = 8'h20;
    spi_done = 1'b1;
    @(negedge clk);
    spi_done = 1'b0;
`ifdef LIGHT_AUTO_EN
    wait_idle(200, "idle_light");
`else
    quiet(30, "quiet_light_disabled");
`endif

    // Abort during cycle 5 of a motor run
    push_exp(1'b1, 2'b10, 5, 0, 10);
    send_rx(8'h31);
    wait_run(10);
    repeat (4) @(negedge clk);
    send_rx(8'h30);
    chk("abort_motor_low", motor_signal, 1'b0);
    wait_idle(200, "idle_abort");

    // Repeated button presses during a button run give one further run
    push_exp(1'b1, 2'b01, 20, 1, 10);
    push_exp(1'b1, 2'b01, 20, 1, 10);
    pulse_bt();
    wait_run(10);
    repeat (3) @(negedge clk);
    pulse_bt();
    repeat (5) @(negedge clk);
    pulse_bt();
    wait_idle(400, "idle_double_button");
    quiet(30, "quiet_after_double_button");

    // Abort during dead time drops a queued request
    push_exp(1'b1, 2'b01, 20, 1, 10);
    pulse_bt();
    wait_run(10);
    repeat (3) @(negedge clk);
    pulse_bt();
    wait_gap(100);
    repeat (2) @(negedge clk);
    send_rx(8'h30);
    wait_idle(200, "idle_gap_abort");
    quiet(30, "quiet_gap_abort");

    // Reset during cycle 8 of a motor run with a queued request
    pulse_bt();
    wait_run(10);
    repeat (2) @(negedge clk);
    pulse_bt();
    repeat (4) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("mid_rst_motor", motor_signal, 1'b0);
    chk("mid_rst_busy",  busy,         1'b0);
    chk("mid_rst_grant", grant,        2'b00);
    @(negedge clk);
    #2 n_rst = 1'b1;
    quiet(40, "quiet_after_reset");

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/actuator_sched.md
ACTUATOR_SCHED -- requirements
Module: actuator_sched

Interface
REQ-001 Parameter TICK_DIV, default 100, clock cycles per one-second tick.
REQ-002 Parameter MOTOR_SEC, default 5, motor run length in ticks.
REQ-003 Parameter HEAT_SEC, default 3, heater run length in ticks.
REQ-004 Parameter LIGHT_TH, default 8'h40, light level below which an auto run is requested.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 n_rst  in  1  reset, asynchronous, active-low.
REQ-007 bt_start  in  1  button pulse, one cycle; requests a motor run.
REQ-008 rx_data  in  8  UART byte; valid only while rx_done=1.
REQ-009 rx_done  in  1  UART byte strobe: 8'h31 motor request, 8'h32 heat request, 8'h30 abort, others ignored.
REQ-010 led_data  in  8  SPI light sample; valid only while spi_done=1.
REQ-011 spi_done  in  1  SPI sample strobe.
REQ-012 motor_signal  out  1  motor enable, registered.
REQ-013 heat_signal  out  1  heater enable, registered.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 grant  out  2  current owner: 00 none, 01 button, 10 UART, 11 light.
REQ-016 done_pulse  out  1  one-cycle pulse when a run completes normally.

Function
REQ-017 Each source has a one-deep pending bit: btn_p (bt_start), um_p (rx 8'h31), uh_p (rx 8'h32), lt_p (spi_done with led_data < LIGHT_TH); set on the edge sampling the strobe.
REQ-018 States: IDLE, MOTOR, HEAT, GAP; motor_signal=1 only in MOTOR, heat_signal=1 only in HEAT; both never high in the same cycle.
REQ-019 In IDLE, fixed priority uh_p > um_p > btn_p > lt_p; the winner is granted and its pending bit cleared on the transition edge.
REQ-020 uh_p goes to HEAT; um_p, btn_p and lt_p go to MOTOR (lt_p is the heater-free auto run).
REQ-021 Latency: strobe sampled at edge N sets pending; IDLE->run at edge N+1; outputs high from edge N+1.
REQ-022 Prescaler 0..TICK_DIV-1 and tick counter restart on every state entry; MOTOR lasts exactly MOTOR_SEC*TICK_DIV cycles, HEAT exactly HEAT_SEC*TICK_DIV cycles.
REQ-023 On normal run end: done_pulse=1 for one cycle at the exit edge, enter GAP, grant=00.
REQ-024 GAP lasts exactly TICK_DIV cycles (dead time), then IDLE; requests during GAP stay pending.
REQ-025 Abort (rx 8'h30) in MOTOR or HEAT: enter GAP next edge, no done_pulse, clear all pending bits; abort in IDLE or GAP clears pending bits only.
REQ-026 A request for a source already pending is absorbed (no count); a request in the same cycle its bit is granted leaves the bit set.
REQ-027 A request from the source currently running sets its pending bit and is served after GAP.
REQ-028 A UART byte other than 8'h30/31/32, or led_data >= LIGHT_TH, has no effect.

Reset
REQ-029 While n_rst=0: state IDLE, all pending bits 0, counters 0, motor_signal=0, heat_signal=0, busy=0, grant=00, done_pulse=0.
REQ-030 Reset asserted mid-run drops outputs immediately (asynchronous); no run resumes after release.
REQ-031 First strobe is honoured on the first rising edge after n_rst deasserts.

Configuration
REQ-032 Macro LIGHT_AUTO_EN: defined -> light source and lt_p present per REQ-017; undefined -> spi_done and led_data ignored, lt_p absent, grant never 11.

Verification (TICK_DIV=10, MOTOR_SEC=2, HEAT_SEC=1, LIGHT_TH=8'h40)
REQ-033 rx_data=8'h31 with rx_done for one cycle -> motor_signal high exactly 20 cycles from next edge, grant=10, done_pulse once, then busy high 10 more cycles.
REQ-034 bt_start and rx 8'h32 same cycle -> HEAT first (10 cycles, grant=10), GAP 10, then MOTOR 20 cycles grant=01; motor and heat never overlap.
REQ-035 spi_done with led_data=8'h20 -> MOTOR grant=11; led_data=8'h50 -> no activity; LIGHT_AUTO_EN undefined -> no activity for both.
REQ-036 rx 8'h31, then rx 8'h30 at cycle 5 of MOTOR -> motor low next edge, no done_pulse, GAP 10 cycles, IDLE.
REQ-037 n_rst low for one cycle at cycle 8 of MOTOR -> all outputs 0 immediately, stays IDLE after release with no new strobe.
REQ-038 bt_start twice during MOTOR (grant=01) -> exactly one further motor run after GAP.
